puf_sequencer: RTL and testbench

Parametrised successor to the on-chip `controller`. It sequences a full PUF operation: oscillator measurement, then BCH encode (enrollment), BCH decode (reconstruction), or encode followed by decode (self-check). It drives the enable/start/reset strobes of the `meas`, `bch_wrapper_encoder` and `bch_wrapper_decoder_mem` blocks and the `syn_mem` address-mux select. It adds a programmable measurement window, per-phase timeout, abort handling and error reporting.

---
 rtl/puf_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_puf_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_sequencer.sv
// PUF operation sequencer: oscillator measurement followed by BCH encode, decode or both,
// with a programmable window, per-phase timeout, abort handling and error reporting.
module puf_sequencer #(
  parameter int unsigned MODE_WIDTH    = 2,
  parameter int unsigned OSC_CNT_WIDTH = 20,
  parameter int unsigned MEAS_RST_CYC  = 4,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic                     I_en,
  input  logic                     I_start,
  input  logic [MODE_WIDTH-1:0]    I_mode,
  input  logic [OSC_CNT_WIDTH-1:0] I_osc_win,
  input  logic [TIMEOUT_WIDTH-1:0] I_timeout,
  output logic                     O_meas_rst,
  input  logic                     I_meas_v,
  output logic                     O_enc_en,
  output logic                     O_enc_start,
  input  logic                     I_enc_ready,
  output logic                     O_dec_en,
  output logic                     O_dec_start,
  input  logic                     I_dec_ready,
  output logic [1:0]               O_mem_sel,
  output logic                     O_busy,
  output logic                     O_ready,
  output logic                     O_err,
  output logic [1:0]               O_err_code
);

  typedef enum logic [3:0] {
    StIdle, StMrst, StMwin, StMwait, StEncSt, StEncWait, StDecSt, StDecWait, StDone
  } state_e;

  localparam logic [OSC_CNT_WIDTH-1:0] OscOne      = OSC_CNT_WIDTH'(1);
  localparam logic [OSC_CNT_WIDTH-1:0] MeasRstLast = OSC_CNT_WIDTH'(MEAS_RST_CYC - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] ToOne       = TIMEOUT_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0]    ModeMeas    = MODE_WIDTH'(0);
  localparam logic [MODE_WIDTH-1:0]    ModeEnroll  = MODE_WIDTH'(1);
  localparam logic [MODE_WIDTH-1:0]    ModeRecon   = MODE_WIDTH'(2);
  localparam logic [MODE_WIDTH-1:0]    ModeVerify  = MODE_WIDTH'(3);

  state_e                     r_state;
  state_e                     w_state_d;
  logic [MODE_WIDTH-1:0]      r_mode;
  logic [OSC_CNT_WIDTH-1:0]   r_win;
  logic [OSC_CNT_WIDTH-1:0]   w_win_last;
  logic [TIMEOUT_WIDTH-1:0]   r_timeout;
  logic [OSC_CNT_WIDTH-1:0]   r_cnt;
  logic [TIMEOUT_WIDTH-1:0]   r_tcnt;
  logic                       w_timeout_hit;
  logic                       w_accept;
  logic                       w_err_set;
  logic [1:0]                 w_err_code;

  logic       r_meas_rst;
  logic       r_enc_en;
  logic       r_enc_start;
  logic       r_dec_en;
  logic       r_dec_start;
  logic [1:0] r_mem_sel;
  logic       r_busy;
  logic       r_ready;
  logic       r_err;
  logic [1:0] r_err_code;

  assign w_win_last    = r_win - OscOne;
  assign w_timeout_hit = (r_timeout != '0) && (r_tcnt == r_timeout);
  assign w_accept      = (r_state == StIdle) && I_en && I_start;

  always_comb begin
    w_state_d  = r_state;
    w_err_set  = 1'b0;
    w_err_code = 2'd0;
    unique case (r_state)
      StIdle: if (w_accept) w_state_d = StMrst;
      StMrst: if (r_cnt == MeasRstLast) w_state_d = StMwin;
      StMwin: if (r_cnt == w_win_last) w_state_d = StMwait;
      StMwait: begin
        // A valid arriving on the timeout cycle still counts as success.
        if (I_meas_v) begin
          if (r_mode == ModeEnroll || r_mode == ModeVerify) w_state_d = StEncSt;
          else if (r_mode == ModeRecon) w_state_d = StDecSt;
          else w_state_d = StDone;
        end else if (w_timeout_hit) begin
          w_state_d  = StDone;
          w_err_set  = 1'b1;
          w_err_code = 2'd1;
        end
      end
      StEncSt: w_state_d = StEncWait;
      StEncWait: begin
        if (I_enc_ready) begin
          w_state_d = (r_mode == ModeVerify) ? StDecSt : StDone;
        end else if (w_timeout_hit) begin
          w_state_d  = StDone;
          w_err_set  = 1'b1;
          w_err_code = 2'd2;
        end
      end
      StDecSt: w_state_d = StDecWait;
      StDecWait: begin
        if (I_dec_ready) begin
          w_state_d = StDone;
        end else if (w_timeout_hit) begin
          w_state_d  = StDone;
          w_err_set  = 1'b1;
          w_err_code = 2'd2;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (r_state != StIdle && r_state != StDone && !I_en) begin
      w_state_d  = StDone;
      w_err_set  = 1'b1;
      w_err_code = 2'd3;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state     <= StIdle;
      r_mode      <= ModeMeas;
      r_win       <= '0;
      r_timeout   <= '0;
      r_cnt       <= '0;
      r_tcnt      <= '0;
      r_meas_rst  <= 1'b0;
      r_enc_en    <= 1'b0;
      r_enc_start <= 1'b0;
      r_dec_en    <= 1'b0;
      r_dec_start <= 1'b0;
      r_mem_sel   <= 2'd0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'd0;
    end else begin
      r_state <= w_state_d;
      // Both counters restart on every state change, so each phase counts from zero.
      if (w_state_d != r_state || r_state == StIdle) begin
        r_cnt  <= '0;
        r_tcnt <= '0;
      end else begin
        r_cnt  <= r_cnt + OscOne;
        r_tcnt <= r_tcnt + ToOne;
      end
      if (w_accept) begin
        r_mode     <= I_mode;
        r_win      <= (I_osc_win == '0) ? OscOne : I_osc_win;
        r_timeout  <= I_timeout;
        r_err      <= 1'b0;
        r_err_code <= 2'd0;
      end else if (w_err_set) begin
        r_err      <= 1'b1;
        r_err_code <= w_err_code;
      end
      r_meas_rst  <= (w_state_d == StMrst);
      r_enc_en    <= (w_state_d == StEncSt) || (w_state_d == StEncWait);
      r_enc_start <= (w_state_d == StEncSt);
      r_dec_en    <= (w_state_d == StDecSt) || (w_state_d == StDecWait);
      r_dec_start <= (w_state_d == StDecSt);
      if (w_state_d == StEncSt || w_state_d == StEncWait) r_mem_sel <= 2'd1;
      else if (w_state_d == StDecSt || w_state_d == StDecWait) r_mem_sel <= 2'd2;
      else r_mem_sel <= 2'd0;
      r_busy  <= (w_state_d != StIdle);
      r_ready <= (w_state_d == StDone);
    end
  end

  assign O_meas_rst  = r_meas_rst;
  assign O_enc_en    = r_enc_en;
  assign O_enc_start = r_enc_start;
  assign O_dec_en    = r_dec_en;
  assign O_dec_start = r_dec_start;
  assign O_mem_sel   = r_mem_sel;
  assign O_busy      = r_busy;
  assign O_ready     = r_ready;
  assign O_err       = r_err;
  assign O_err_code  = r_err_code;

endmodule

// File: tb/tb_puf_sequencer.sv
// Directed bench for puf_sequencer: per-cycle event capture relative to the start edge,
// compared against hand-computed cycle numbers.
module tb_puf_sequencer;

  logic        I_clk;
  logic        I_rst;
  logic        I_en;
  logic        I_start;
  logic [1:0]  I_mode;
  logic [19:0] I_osc_win;
  logic [15:0] I_timeout;
  logic        O_meas_rst;
  logic        I_meas_v;
  logic        O_enc_en;
  logic        O_enc_start;
  logic        I_enc_ready;
  logic        O_dec_en;
  logic        O_dec_start;
  logic        I_dec_ready;
  logic [1:0]  O_mem_sel;
  logic        O_busy;
  logic        O_ready;
  logic        O_err;
  logic [1:0]  O_err_code;
  logic [11:0] w_outs;

  puf_sequencer #(
    .MODE_WIDTH   (2),
    .OSC_CNT_WIDTH(20),
    .MEAS_RST_CYC (4),
    .TIMEOUT_WIDTH(16)
  ) u_dut (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .I_en       (I_en),
    .I_start    (I_start),
    .I_mode     (I_mode),
    .I_osc_win  (I_osc_win),
    .I_timeout  (I_timeout),
    .O_meas_rst (O_meas_rst),
    .I_meas_v   (I_meas_v),
    .O_enc_en   (O_enc_en),
    .O_enc_start(O_enc_start),
    .I_enc_ready(I_enc_ready),
    .O_dec_en   (O_dec_en),
    .O_dec_start(O_dec_start),
    .I_dec_ready(I_dec_ready),
    .O_mem_sel  (O_mem_sel),
    .O_busy     (O_busy),
    .O_ready    (O_ready),
    .O_err      (O_err),
    .O_err_code (O_err_code)
  );

  assign w_outs = {O_busy, O_ready, O_err, O_err_code, O_meas_rst, O_enc_en, O_enc_start,
                   O_dec_en, O_dec_start, O_mem_sel};

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  int cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;
  int base    = 0;
  int rel     = 0;

  // Events captured per operation, in cycles after the start edge.
  int ready_cnt, ready_cyc, ready_err, ready_code;
  int mrst_cnt, mrst_first, mrst_last;
  int enc_st_cnt, enc_st_cyc, dec_st_cnt, dec_st_cyc;
  int enc_last, dec_last, overlap, sel_bad, sel_seq, prev_sel, busy_fall;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    int exp_sel;
    @(negedge I_clk);
    rel = cyc - base;
    if (O_ready) begin
      ready_cnt++;
      ready_cyc  = rel;
      ready_err  = int'(O_err);
      ready_code = int'(O_err_code);
    end
    if (O_meas_rst) begin
      if (mrst_cnt == 0) mrst_first = rel;
      mrst_cnt++;
      mrst_last = rel;
    end
    if (O_enc_start) begin enc_st_cnt++; enc_st_cyc = rel; end
    if (O_dec_start) begin dec_st_cnt++; dec_st_cyc = rel; end
    if (O_enc_en) enc_last = rel;
    if (O_dec_en) dec_last = rel;
    if (O_enc_en && O_dec_en) overlap++;
    exp_sel = O_enc_en ? 1 : (O_dec_en ? 2 : 0);
    if (int'(O_mem_sel) != exp_sel) sel_bad++;
    if (int'(O_mem_sel) != prev_sel) begin
      sel_seq  = ((sel_seq << 2) | int'(O_mem_sel)) & 63;
      prev_sel = int'(O_mem_sel);
    end
    if (!O_busy && busy_fall == 0 && rel > 0) busy_fall = rel;
  endtask

  task automatic start_op(input int mode, input int win, input int to);
    I_en        = 1'b1;
    I_start     = 1'b1;
    I_mode      = 2'(mode);
    I_osc_win   = 20'(win);
    I_timeout   = 16'(to);
    I_meas_v    = 1'b0;
    I_enc_ready = 1'b0;
    I_dec_ready = 1'b0;
    ready_cnt = 0; ready_cyc = 0; ready_err = 0; ready_code = 0;
    mrst_cnt = 0; mrst_first = 0; mrst_last = 0;
    enc_st_cnt = 0; enc_st_cyc = 0; dec_st_cnt = 0; dec_st_cyc = 0;
    enc_last = 0; dec_last = 0; overlap = 0; sel_bad = 0; sel_seq = 0; prev_sel = 0;
    busy_fall = 0;
    base = cyc;
    rel  = 0;
  endtask

  // Runs until relative cycle n; each input pulses on the named cycle (1000 = never).
  task automatic run(input int n, input int mv, input int er, input int dr, input int en_off,
                     input int st_at);
    while (rel < n) begin
      step();
      I_start     = (rel == st_at);
      I_meas_v    = (rel == mv);
      I_enc_ready = (rel == er);
      I_dec_ready = (rel == dr);
      I_en        = !(rel >= en_off && rel < en_off + 2);
    end
  endtask

  initial begin
    I_rst = 1'b1; I_en = 1'b0; I_start = 1'b0; I_mode = 2'd0; I_osc_win = 20'd0;
    I_timeout = 16'd0; I_meas_v = 1'b0; I_enc_ready = 1'b0; I_dec_ready = 1'b0;
    repeat (3) step();
    check_eq("reset_outs", int'(w_outs), 0);
    I_rst = 1'b0;
    step();

    // Reset held for three cycles in the middle of ENC_WAIT.
    start_op(1, 2, 0);
    run(12, 7, 1000, 1000, 1000, 1000);
    check_eq("pre_rst_enc_en", int'(O_enc_en), 1);
    check_eq("pre_rst_mem_sel", int'(O_mem_sel), 1);
    I_rst = 1'b1;
    step();
    check_eq("rst_mid_outs", int'(w_outs), 0);
    step();
    step();
    check_eq("rst_end_outs", int'(w_outs), 0);
    I_rst = 1'b0;
    // Window of 0 behaves as 1: MWAIT at 4+1+1.
    start_op(0, 0, 0);
    run(12, 6, 1000, 1000, 1000, 1000);
    check_eq("win0_ready_cyc", ready_cyc, 7);
    check_eq("win0_ready_cnt", ready_cnt, 1);
    check_eq("win0_err", ready_err, 0);

    // Measure only, window 10, valid two cycles after the window.
    start_op(0, 10, 0);
    run(30, 17, 1000, 1000, 1000, 1000);
    check_eq("m0_mrst_cnt", mrst_cnt, 4);
    check_eq("m0_mrst_first", mrst_first, 1);
    check_eq("m0_mrst_last", mrst_last, 4);
    check_eq("m0_ready_cyc", ready_cyc, 18);
    check_eq("m0_ready_cnt", ready_cnt, 1);
    check_eq("m0_err", ready_err, 0);
    check_eq("m0_enc_dec_starts", enc_st_cnt + dec_st_cnt, 0);
    check_eq("m0_enc_dec_en", enc_last + dec_last, 0);
    check_eq("m0_busy_fall", busy_fall, 19);

    // Enroll+verify: encoder ready 30 cycles after start, decoder 50 after its start.
    start_op(3, 5, 0);
    run(100, 11, 42, 93, 1000, 1000);
    check_eq("m3_enc_st_cnt", enc_st_cnt, 1);
    check_eq("m3_enc_st_cyc", enc_st_cyc, 12);
    check_eq("m3_dec_st_cnt", dec_st_cnt, 1);
    check_eq("m3_dec_st_cyc", dec_st_cyc, 43);
    check_eq("m3_enc_last", enc_last, 42);
    check_eq("m3_dec_last", dec_last, 93);
    check_eq("m3_ready_cyc", ready_cyc, 94);
    check_eq("m3_ready_cnt", ready_cnt, 1);
    check_eq("m3_err", ready_err, 0);
    check_eq("m3_sel_seq", sel_seq, 24);
    check_eq("m3_overlap", overlap, 0);
    check_eq("m3_sel_bad", sel_bad, 0);
    check_eq("m3_busy_fall", busy_fall, 95);

    // Reconstruct with decoder never ready: timeout 20 after DEC_WAIT entry at cycle 10.
    start_op(2, 3, 20);
    run(36, 8, 1000, 1000, 1000, 1000);
    check_eq("m2_dec_st_cyc", dec_st_cyc, 9);
    check_eq("m2_dec_last", dec_last, 30);
    check_eq("m2_ready_cyc", ready_cyc, 31);
    check_eq("m2_err", ready_err, 1);
    check_eq("m2_code", ready_code, 2);
    check_eq("m2_enc_st_cnt", enc_st_cnt, 0);
    check_eq("m2_dec_en_after", int'(O_dec_en), 0);
    check_eq("m2_err_sticky", int'(O_err), 1);
    check_eq("m2_code_sticky", int'(O_err_code), 2);
    check_eq("m2_busy_after", int'(O_busy), 0);

    // Measurement valid never arrives: timeout 3 after MWAIT entry at cycle 6.
    start_op(0, 1, 3);
    run(14, 1000, 1000, 1000, 1000, 1000);
    check_eq("mt_ready_cyc", ready_cyc, 10);
    check_eq("mt_code", ready_code, 1);
    check_eq("mt_err", ready_err, 1);

    // Abort: enable dropped during MWIN.
    start_op(1, 10, 0);
    run(14, 1000, 1000, 1000, 7, 1000);
    check_eq("ab_ready_cyc", ready_cyc, 8);
    check_eq("ab_err", ready_err, 1);
    check_eq("ab_code", ready_code, 3);
    check_eq("ab_mrst_cnt", mrst_cnt, 4);
    check_eq("ab_enc_st_cnt", enc_st_cnt, 0);
    check_eq("ab_busy_fall", busy_fall, 9);
    start_op(0, 2, 0);
    run(1, 1000, 1000, 1000, 1000, 1000);
    check_eq("ab_restart_err", int'(O_err), 0);
    check_eq("ab_restart_code", int'(O_err_code), 0);
    run(12, 7, 1000, 1000, 1000, 1000);
    check_eq("ab_restart_ready", ready_cyc, 8);
    check_eq("ab_restart_ready_err", ready_err, 0);

    // Encoder ready on the exact timeout cycle, plus a start pulse while busy.
    start_op(1, 2, 5);
    run(30, 7, 14, 1000, 1000, 10);
    check_eq("co_ready_cnt", ready_cnt, 1);
    check_eq("co_ready_cyc", ready_cyc, 15);
    check_eq("co_err", ready_err, 0);
    check_eq("co_enc_st_cnt", enc_st_cnt, 1);
    check_eq("co_err_final", int'(O_err), 0);
    check_eq("co_busy_final", int'(O_busy), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
